// File: rtl/counter_disp_scan_if.sv
// Bundle of the counter/display control and status signals between the
// user-project pads (master side) and counter_disp_scan (slave side).
interface counter_disp_scan_if #(
  parameter int NUM_BITS = 8,
  parameter int NUM_DISP = 3
);
  logic                cnt_start;
  logic                cnt_stop;
  logic                cnt_rst;
  logic                cnt_dir;
  logic                cnt_wrap;
  logic [NUM_BITS-1:0] cnt_max;
  logic [NUM_BITS-1:0] cnt_val;
  logic                running;
  logic                tc;
  logic                conv_busy;
  logic [6:0]          seg_out;
  logic [NUM_DISP-1:0] dig_en;

  modport master (
    output cnt_start, cnt_stop, cnt_rst, cnt_dir, cnt_wrap, cnt_max,
    input  cnt_val, running, tc, conv_busy, seg_out, dig_en
  );

  modport slave (
    input  cnt_start, cnt_stop, cnt_rst, cnt_dir, cnt_wrap, cnt_max,
    output cnt_val, running, tc, conv_busy, seg_out, dig_en
  );
endinterface

// File: rtl/counter_disp_scan.sv
// Up/down counter with prescaler and wrap/saturate modes, feeding a sequential
// double-dabble BCD converter and an active-low multiplexed 7-segment scanner.
module counter_disp_scan #(
  parameter int NUM_BITS = 8,
  parameter int NUM_DISP = 3,
  parameter int TICK_DIV = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic               clk,
  input  logic               rst,
  counter_disp_scan_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
  localparam int KW = $clog2(NUM_BITS + 1);
  localparam int BW = 4 * NUM_DISP;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DISP - 1);
  localparam logic [KW-1:0] BIT_LAST   = KW'(NUM_BITS - 1);

  typedef enum logic {S_STOP, S_RUN} run_state_t;
  typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_DONE} conv_state_t;

  run_state_t          state_q, state_n;
  logic [NUM_BITS-1:0] cnt_q, cnt_n;
  logic [PW-1:0]       presc_q, presc_n;
  logic                tc_q, tc_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_STOP;
      cnt_q   <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      presc_q <= presc_n;
      tc_q    <= tc_n;
    end
  end

  // Clear beats stop beats start; a step only happens on the last prescaler count in RUN.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    presc_n = presc_q;
    tc_n    = 1'b0;
    if (bus.cnt_rst) begin
      cnt_n   = bus.cnt_dir ? '0 : bus.cnt_max;
      presc_n = '0;
      state_n = S_STOP;
    end else if (bus.cnt_stop) begin
      state_n = S_STOP;
    end else if (state_q == S_STOP) begin
      if (bus.cnt_start) begin
        state_n = S_RUN;
        presc_n = '0;
      end
    end else if (presc_q != PRESC_LAST) begin
      presc_n = presc_q + 1'b1;
    end else begin
      presc_n = '0;
      if (bus.cnt_dir) begin
        if (cnt_q >= bus.cnt_max) begin
          tc_n = 1'b1;
          if (bus.cnt_wrap) begin
            cnt_n = '0;
          end else begin
            cnt_n   = bus.cnt_max;
            state_n = S_STOP;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          tc_n = 1'b1;
          if (bus.cnt_wrap) begin
            cnt_n = bus.cnt_max;
          end else begin
            state_n = S_STOP;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
    end
  end

  conv_state_t         c_state_q, c_state_n;
  logic [NUM_BITS-1:0] cap_q, cap_n;
  logic [NUM_BITS-1:0] last_q, last_n;
  logic [BW-1:0]       scratch_q, scratch_n;
  logic [BW-1:0]       bcd_q, bcd_n;
  logic [BW-1:0]       adj;
  logic [KW-1:0]       bit_q, bit_n;
  logic                busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_state_q <= C_IDLE;
      cap_q     <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      c_state_q <= c_state_n;
      cap_q     <= cap_n;
      last_q    <= last_n;
      scratch_q <= scratch_n;
      bcd_q     <= bcd_n;
      bit_q     <= bit_n;
      busy_q    <= (c_state_n != C_IDLE);
    end
  end

  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < NUM_DISP; k++) begin
      if (scratch_q[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = scratch_q[k*4 +: 4] + 4'd3;
    end
  end

  // The captured value is rotated rather than shifted so it is intact again
  // after NUM_BITS steps and can be recorded as the last converted value.
  always_comb begin
    c_state_n = c_state_q;
    cap_n     = cap_q;
    last_n    = last_q;
    scratch_n = scratch_q;
    bcd_n     = bcd_q;
    bit_n     = bit_q;
    case (c_state_q)
      C_IDLE: begin
        if (cnt_q != last_q) begin
          cap_n     = cnt_q;
          scratch_n = '0;
          bit_n     = '0;
          c_state_n = C_SHIFT;
        end
      end
      C_SHIFT: begin
        scratch_n = {adj[BW-2:0], cap_q[NUM_BITS-1]};
        cap_n     = {cap_q[NUM_BITS-2:0], cap_q[NUM_BITS-1]};
        bit_n     = bit_q + 1'b1;
        if (bit_q == BIT_LAST) c_state_n = C_DONE;
      end
      C_DONE: begin
        bcd_n     = scratch_q;
        last_n    = cap_q;
        c_state_n = C_IDLE;
      end
      default: c_state_n = C_IDLE;
    endcase
  end

  logic [SW-1:0]       scan_q;
  logic [IW-1:0]       idx_q;
  logic [6:0]          seg_q, seg_n;
  logic [NUM_DISP-1:0] dig_q, dig_n;
  logic [3:0]          digit;
  logic                lead_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= 7'h7F;
      dig_q  <= '1;
    end else begin
      seg_q <= seg_n;
      dig_q <= dig_n;
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  // A digit is blank when it and every more-significant digit are zero; digit 0 never blanks.
  always_comb begin
    digit     = 4'd0;
    lead_zero = 1'b1;
    dig_n     = '1;
    seg_n     = 7'h7F;
    for (int k = 0; k < NUM_DISP; k++) begin
      if (k == int'(idx_q)) begin
        digit    = bcd_q[k*4 +: 4];
        dig_n[k] = 1'b0;
      end
      if (k >= int'(idx_q) && bcd_q[k*4 +: 4] != 4'd0) lead_zero = 1'b0;
    end
    case (digit)
      4'd0:    seg_n = 7'h40;
      4'd1:    seg_n = 7'h79;
      4'd2:    seg_n = 7'h24;
      4'd3:    seg_n = 7'h30;
      4'd4:    seg_n = 7'h19;
      4'd5:    seg_n = 7'h12;
      4'd6:    seg_n = 7'h02;
      4'd7:    seg_n = 7'h78;
      4'd8:    seg_n = 7'h00;
      4'd9:    seg_n = 7'h10;
      default: seg_n = 7'h7F;
    endcase
    if (lead_zero && idx_q != '0) seg_n = 7'h7F;
  end

  assign bus.cnt_val   = cnt_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.tc        = tc_q;
  assign bus.conv_busy = busy_q;
  assign bus.seg_out   = seg_q;
  assign bus.dig_en    = dig_q;
endmodule

// File: tb/tb_counter_disp_scan.sv
// Bench for counter_disp_scan: a value-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_counter_disp_scan;
  localparam int NUM_BITS = 8;
  localparam int NUM_DISP = 3;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   checking = 1'b0;

  counter_disp_scan_if #(.NUM_BITS(NUM_BITS), .NUM_DISP(NUM_DISP)) bus ();

  counter_disp_scan #(
    .NUM_BITS(NUM_BITS), .NUM_DISP(NUM_DISP),
    .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] seg_of(int val, int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && val < p) return 7'h7F;
    return seg_tab[(val / p) % 10];
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: counter value and running flag, conversion as a job that
  // lands NUM_BITS+2 edges after it starts, scanner index from elapsed cycles.
  int         m_cnt = 0, m_presc = 0, m_left = 0, m_job = 0, m_last = 0;
  int         m_disp = 0, m_edges = 0;
  bit         m_run = 1'b0, m_tc = 1'b0;
  logic [6:0] e_seg = 7'h7F;
  logic [2:0] e_dig = 3'b111;

  always @(posedge clk or negedge rst) begin : model
    int idx;
    int mx;
    if (!rst) begin
      m_cnt = 0; m_presc = 0; m_left = 0; m_job = 0; m_last = 0;
      m_disp = 0; m_edges = 0; m_run = 1'b0; m_tc = 1'b0;
      e_seg = 7'h7F; e_dig = 3'b111;
    end else begin
      idx   = (m_edges / SCAN_DIV) % NUM_DISP;
      e_dig = ~(3'b001 << idx);
      e_seg = seg_of(m_disp, idx);
      m_edges++;
      if (m_left == 0) begin
        if (m_cnt != m_last) begin
          m_job  = m_cnt;
          m_left = NUM_BITS + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_job;
          m_last = m_job;
        end
      end
      mx   = int'(bus.cnt_max);
      m_tc = 1'b0;
      if (bus.cnt_rst) begin
        m_cnt = bus.cnt_dir ? 0 : mx;
        m_presc = 0;
        m_run = 1'b0;
      end else if (bus.cnt_stop) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        if (bus.cnt_start) begin
          m_run = 1'b1;
          m_presc = 0;
        end
      end else if (m_presc < TICK_DIV - 1) begin
        m_presc++;
      end else begin
        m_presc = 0;
        if (bus.cnt_dir) begin
          if (m_cnt >= mx) begin
            m_tc = 1'b1;
            if (bus.cnt_wrap) m_cnt = 0;
            else begin m_cnt = mx; m_run = 1'b0; end
          end else m_cnt++;
        end else begin
          if (m_cnt == 0) begin
            m_tc = 1'b1;
            if (bus.cnt_wrap) m_cnt = mx;
            else m_run = 1'b0;
          end else m_cnt--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check_output("cyc cnt_val",   int'(bus.cnt_val),   m_cnt);
      check_output("cyc running",   int'(bus.running),   int'(m_run));
      check_output("cyc tc",        int'(bus.tc),        int'(m_tc));
      check_output("cyc conv_busy", int'(bus.conv_busy), int'(m_left != 0));
      check_output("cyc seg_out",   int'(bus.seg_out),   int'(e_seg));
      check_output("cyc dig_en",    int'(bus.dig_en),    int'(e_dig));
    end
  end

  task automatic apply_stimulus(input bit start, input bit stop, input bit clr);
    bus.cnt_start = start;
    bus.cnt_stop  = stop;
    bus.cnt_rst   = clr;
    @(negedge clk);
    bus.cnt_start = 1'b0;
    bus.cnt_stop  = 1'b0;
    bus.cnt_rst   = 1'b0;
  endtask

  task automatic wait_for_cnt(input int val, input int bound);
    int n = 0;
    while (int'(bus.cnt_val) != val && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_output("wait cnt_val", int'(bus.cnt_val), val);
  endtask

  task automatic read_digit(input int k, output logic [6:0] seg, output int hold);
    int guard = 0;
    seg  = 7'h7F;
    hold = 0;
    while (bus.dig_en[k] == 1'b0 && guard < 64) begin @(negedge clk); guard++; end
    while (bus.dig_en[k] == 1'b1 && guard < 64) begin @(negedge clk); guard++; end
    seg = bus.seg_out;
    while (bus.dig_en[k] == 1'b0 && guard < 64) begin hold++; @(negedge clk); guard++; end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d0,
                              input logic [6:0] d1, input logic [6:0] d2);
    logic [6:0] s;
    int h;
    read_digit(0, s, h);
    check_output({tag, " digit0"}, int'(s), int'(d0));
    read_digit(1, s, h);
    check_output({tag, " digit1"}, int'(s), int'(d1));
    read_digit(2, s, h);
    check_output({tag, " digit2"}, int'(s), int'(d2));
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] s;
    int h;
    int lat;
    bit seen;
    bus.cnt_start = 1'b0;
    bus.cnt_stop  = 1'b0;
    bus.cnt_rst   = 1'b0;
    bus.cnt_dir   = 1'b1;
    bus.cnt_wrap  = 1'b1;
    bus.cnt_max   = 8'd9;
    #1 rst = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("reset seg_out", int'(bus.seg_out), 'h7F);
    check_output("reset dig_en",  int'(bus.dig_en),  'b111);
    check_output("reset cnt_val", int'(bus.cnt_val), 0);
    @(negedge clk);
    check_output("release seg_out", int'(bus.seg_out), 'h40);
    check_output("release dig_en",  int'(bus.dig_en),  'b110);

    $display("[TB] up count with wrap, cnt_max=9");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("start running", int'(bus.running), 1);
    for (int v = 1; v <= 9; v++) begin
      repeat (TICK_DIV - 1) @(negedge clk);
      check_output("up pre-step", int'(bus.cnt_val), v - 1);
      @(negedge clk);
      check_output("up step", int'(bus.cnt_val), v);
    end
    repeat (TICK_DIV) @(negedge clk);
    check_output("wrap cnt_val", int'(bus.cnt_val), 0);
    check_output("wrap tc",      int'(bus.tc),      1);
    check_output("wrap running", int'(bus.running), 1);
    @(negedge clk);
    check_output("wrap tc width", int'(bus.tc), 0);

    $display("[TB] down count with saturate from 3");
    wait_for_cnt(3, 40);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("stop running", int'(bus.running), 0);
    bus.cnt_dir  = 1'b0;
    bus.cnt_wrap = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    for (int v = 2; v >= 0; v--) begin
      repeat (TICK_DIV) @(negedge clk);
      check_output("down step", int'(bus.cnt_val), v);
    end
    repeat (TICK_DIV) @(negedge clk);
    check_output("sat tc",      int'(bus.tc),      1);
    check_output("sat running", int'(bus.running), 0);
    check_output("sat cnt_val", int'(bus.cnt_val), 0);
    repeat (20) @(negedge clk);
    check_output("sat hold", int'(bus.cnt_val), 0);

    $display("[TB] priority checks");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("start+stop running", int'(bus.running), 0);
    bus.cnt_max = 8'd200;
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("rst+start cnt_val", int'(bus.cnt_val), 200);
    check_output("rst+start running", int'(bus.running), 0);
    repeat (15) @(negedge clk);

    $display("[TB] display of 123 and conversion latency");
    bus.cnt_max = 8'd123;
    apply_stimulus(1'b0, 1'b0, 1'b1);
    lat  = 31;
    seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.conv_busy) seen = 1'b1;
      else if (seen) begin
        lat = k;
        break;
      end
    end
    check_output("bcd latency", lat, NUM_BITS + 2);
    check_digits("val123", 7'h30, 7'h24, 7'h79);
    read_digit(0, s, h);
    check_output("digit0 dwell", h, SCAN_DIV);

    $display("[TB] leading-zero blanking with 7");
    bus.cnt_max = 8'd7;
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    check_digits("val7", 7'h78, 7'h7F, 7'h7F);

    $display("[TB] change during conversion 45 then 61");
    bus.cnt_max = 8'd45;
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_output("busy mid conv", int'(bus.conv_busy), 1);
    bus.cnt_max = 8'd61;
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    check_digits("val61", 7'h79, 7'h02, 7'h7F);

    $display("[TB] async reset while running at 37");
    bus.cnt_dir  = 1'b1;
    bus.cnt_wrap = 1'b1;
    bus.cnt_max  = 8'd100;
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_for_cnt(37, 200);
    check_output("pre-reset running", int'(bus.running), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async cnt_val",   int'(bus.cnt_val),   0);
    check_output("async running",   int'(bus.running),   0);
    check_output("async tc",        int'(bus.tc),        0);
    check_output("async conv_busy", int'(bus.conv_busy), 0);
    check_output("async seg_out",   int'(bus.seg_out),   'h7F);
    check_output("async dig_en",    int'(bus.dig_en),    'b111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("post seg_out", int'(bus.seg_out), 'h40);
    check_output("post dig_en",  int'(bus.dig_en),  'b110);
    repeat (2) @(negedge clk);
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
